// File: rtl/interp_segment_finder_pkg.sv
// Shared types for the interpolation front end: FSM states, result status codes,
// format defaults and table-entry field helpers.
package interp_pkg;

  localparam int DATA_WIDTH_DEF = 128;
  localparam int ADDR_WIDTH_DEF = 6;
  localparam int FRAC_BITS_DEF  = 33;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    CHECK = 3'd2,
    START = 3'd3,
    WAIT  = 3'd4,
    OUT   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    ST_INTERP   = 2'd0,
    ST_CLAMP_LO = 2'd1,
    ST_CLAMP_HI = 2'd2,
    ST_HIT      = 2'd3
  } status_e;

  // A table entry packs {x, y}, abscissa in the upper half.
  function automatic logic [63:0] entry_x(input logic [DATA_WIDTH_DEF-1:0] e);
    return e[DATA_WIDTH_DEF-1:64];
  endfunction

  function automatic logic [63:0] entry_y(input logic [DATA_WIDTH_DEF-1:0] e);
    return e[63:0];
  endfunction

endpackage

// File: rtl/interp_segment_finder_if.sv
// Bundle of the finder's query, table-memory, interpolator and result ports.
// Handshakes: query and result transfer on a cycle where valid && ready are both high;
// valid, once raised, holds with stable payload until ready; mem_rdata follows mem_rd by
// one cycle; interp_result is meaningful only while interp_done is high.
interface interp_segment_finder_if #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 6
);
  logic                  query_valid;
  logic                  query_ready;
  logic [63:0]           query_x;
  logic [ADDR_WIDTH:0]   tbl_len;
  logic                  mem_rd;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  interp_start;
  logic [63:0]           interp_x;
  logic [DATA_WIDTH-1:0] interp_x0;
  logic [DATA_WIDTH-1:0] interp_x1;
  logic                  interp_done;
  logic [DATA_WIDTH-1:0] interp_result;
  logic                  res_valid;
  logic                  res_ready;
  logic [DATA_WIDTH-1:0] res_data;
  logic [1:0]            res_status;

  // master: the segment finder itself (it masters the table memory and the interpolator).
  modport master (
    input  query_valid, query_x, tbl_len, mem_rdata, interp_done, interp_result, res_ready,
    output query_ready, mem_rd, mem_addr, interp_start, interp_x, interp_x0, interp_x1,
           res_valid, res_data, res_status
  );

  // slave: the surrounding environment (query source, memory, interpolator, consumer).
  modport slave (
    output query_valid, query_x, tbl_len, mem_rdata, interp_done, interp_result, res_ready,
    input  query_ready, mem_rd, mem_addr, interp_start, interp_x, interp_x0, interp_x1,
           res_valid, res_data, res_status
  );
endinterface

// File: rtl/interp_segment_finder.sv
// Linear scan of a sorted breakpoint table to find the segment bracketing a query x;
// hits and out-of-range queries are answered directly, others go through the interpolator.
module interp_segment_finder
  import interp_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int FRAC_BITS  = FRAC_BITS_DEF
) (
  input  logic                    clk,
  input  logic                    reset_n,
  interp_segment_finder_if.master bus,
  output state_e                  dbg_state_o
);

  state_e                state_q, state_d;
  logic [63:0]           x_q, x_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [DATA_WIDTH-1:0] prev_q, prev_d;
  logic [63:0]           ix_q, ix_d;
  logic [DATA_WIDTH-1:0] x0_q, x0_d;
  logic [DATA_WIDTH-1:0] x1_q, x1_d;
  logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
  status_e               res_status_q, res_status_d;

  logic [DATA_WIDTH-1:0] cur;
  logic [63:0]           cur_x;
  logic [DATA_WIDTH-1:0] cur_y_sh;
  logic                  last_entry;

  assign cur        = bus.mem_rdata;
  assign cur_x      = entry_x(cur);
  assign cur_y_sh   = DATA_WIDTH'(entry_y(cur)) << FRAC_BITS;
  assign last_entry = ({1'b0, idx_q} == (len_q - (ADDR_WIDTH+1)'(1)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      x_q          <= '0;
      len_q        <= '0;
      idx_q        <= '0;
      prev_q       <= '0;
      ix_q         <= '0;
      x0_q         <= '0;
      x1_q         <= '0;
      res_data_q   <= '0;
      res_status_q <= ST_INTERP;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      prev_q       <= prev_d;
      ix_q         <= ix_d;
      x0_q         <= x0_d;
      x1_q         <= x1_d;
      res_data_q   <= res_data_d;
      res_status_q <= res_status_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    len_d        = len_q;
    idx_d        = idx_q;
    prev_d       = prev_q;
    ix_d         = ix_q;
    x0_d         = x0_q;
    x1_d         = x1_q;
    res_data_d   = res_data_q;
    res_status_d = res_status_q;

    unique case (state_q)
      IDLE: begin
        if (bus.query_valid) begin
          x_d   = bus.query_x;
          len_d = bus.tbl_len;
          idx_d = '0;
          if (bus.tbl_len == '0) begin
            res_data_d   = '0;
            res_status_d = ST_CLAMP_LO;
            state_d      = OUT;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: state_d = CHECK;
      CHECK: begin
        if (cur_x == x_q) begin
          res_data_d   = cur_y_sh;
          res_status_d = ST_HIT;
          state_d      = OUT;
        end else if (cur_x > x_q) begin
          if (idx_q == '0) begin
            res_data_d   = cur_y_sh;
            res_status_d = ST_CLAMP_LO;
            state_d      = OUT;
          end else begin
            ix_d    = x_q;
            x0_d    = prev_q;
            x1_d    = cur;
            state_d = START;
          end
        end else if (last_entry) begin
          // Reaching the last entry below x ends the scan, so even an unsorted table terminates.
          res_data_d   = cur_y_sh;
          res_status_d = ST_CLAMP_HI;
          state_d      = OUT;
        end else begin
          prev_d  = cur;
          idx_d   = idx_q + ADDR_WIDTH'(1);
          state_d = ISSUE;
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        if (bus.interp_done) begin
          res_data_d   = bus.interp_result;
          res_status_d = ST_INTERP;
          state_d      = OUT;
        end
      end
      OUT: begin
        if (bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // query_ready is gated by reset_n so it reads low for the whole reset interval.
  assign bus.query_ready  = reset_n && (state_q == IDLE);
  assign bus.mem_rd       = (state_q == ISSUE);
  assign bus.mem_addr     = idx_q;
  assign bus.interp_start = (state_q == START);
  assign bus.interp_x     = ix_q;
  assign bus.interp_x0    = x0_q;
  assign bus.interp_x1    = x1_q;
  assign bus.res_valid    = (state_q == OUT);
  assign bus.res_data     = res_data_q;
  assign bus.res_status   = res_status_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_interp_segment_finder.sv
// Bench for interp_segment_finder: table memory and interpolator models, directed scenarios,
// then randomized tables and queries checked by a scoreboard against a search-based model.
module tb_interp_segment_finder;
  import interp_pkg::*;

  localparam int FRAC = 33;

  typedef struct packed {
    logic [1:0]   st;
    logic [127:0] data;
    logic [7:0]   reads;
    logic         is_interp;
    logic [63:0]  x;
    logic [127:0] x0;
    logic [127:0] x1;
  } exp_t;

  logic   clk;
  logic   reset_n;
  state_e dbg_state;

  interp_segment_finder_if #(.DATA_WIDTH(128), .ADDR_WIDTH(6)) bus();

  interp_segment_finder #(.DATA_WIDTH(128), .ADDR_WIDTH(6), .FRAC_BITS(33)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset / shared state ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];
  logic [127:0] mem [64];
  int   rr_mode = 0;
  logic fixed_mode = 1'b1;
  int   done_count = 0;
  int   n_accepts = 0;
  int   n_starts = 0;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [127:0] interp_fn(input logic [63:0] x, input logic [127:0] a,
                                             input logic [127:0] b);
    if (fixed_mode) return 128'hABC;
    return a ^ {b[63:0], b[127:64]} ^ {64'h0, x};
  endfunction

  function automatic exp_t ref_model(input logic [63:0] q, input int len);
    exp_t e;
    int i;
    logic [127:0] y;
    e = '0;
    if (len == 0) begin
      e.st = ST_CLAMP_LO;
      return e;
    end
    i = 0;
    while (i < len && mem[i][127:64] < q) i++;
    if (i == len) begin
      e.st = ST_CLAMP_HI;
      y = {64'h0, mem[len-1][63:0]};
      e.data = y << FRAC;
      e.reads = 8'(len);
    end else if (mem[i][127:64] == q) begin
      e.st = ST_HIT;
      y = {64'h0, mem[i][63:0]};
      e.data = y << FRAC;
      e.reads = 8'(i + 1);
    end else if (i == 0) begin
      e.st = ST_CLAMP_LO;
      y = {64'h0, mem[0][63:0]};
      e.data = y << FRAC;
      e.reads = 8'd1;
    end else begin
      e.st = ST_INTERP;
      e.is_interp = 1'b1;
      e.x = q;
      e.x0 = mem[i-1];
      e.x1 = mem[i];
      e.data = interp_fn(q, mem[i-1], mem[i]);
      e.reads = 8'(i + 1);
    end
    return e;
  endfunction

  // ---------------- environment models ----------------
  always @(posedge clk) if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];

  always @(posedge clk) begin
    #1;
    case (rr_mode)
      0:       bus.res_ready = 1'b1;
      1:       bus.res_ready = ($urandom_range(0, 3) != 0);
      default: bus.res_ready = 1'b0;
    endcase
  end

  initial begin : interp_model
    int d;
    logic [127:0] r;
    bus.interp_done = 1'b0;
    bus.interp_result = '0;
    forever begin
      @(negedge clk);
      if (reset_n && bus.interp_start) begin
        d = fixed_mode ? 130 : $urandom_range(1, 20);
        r = interp_fn(bus.interp_x, bus.interp_x0, bus.interp_x1);
        repeat (d) @(posedge clk);
        #1;
        bus.interp_done = 1'b1;
        bus.interp_result = r;
        done_count++;
        @(posedge clk);
        #1;
        bus.interp_done = 1'b0;
        bus.interp_result = '0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int acc_cyc, start_cyc, done_cyc, rise_cyc, reads_q, starts_q;
  logic prev_valid = 1'b0, hold_valid = 1'b0;
  logic [127:0] hold_data, st_x0, st_x1;
  logic [1:0] hold_st;
  logic [63:0] st_x;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset_n) begin
      prev_valid = 1'b0;
      hold_valid = 1'b0;
      reads_q = 0;
      starts_q = 0;
    end else begin
      if (bus.query_valid && bus.query_ready) begin
        acc_cyc = cyc;
        reads_q = 0;
        starts_q = 0;
        n_accepts++;
      end
      if (bus.mem_rd) begin
        chk("mem_addr", 128'(bus.mem_addr), 128'(reads_q));
        reads_q++;
      end
      if (bus.interp_start) begin
        start_cyc = cyc;
        starts_q++;
        n_starts++;
        st_x = bus.interp_x;
        st_x0 = bus.interp_x0;
        st_x1 = bus.interp_x1;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL stray_start: interp_start with no query outstanding");
        end else begin
          e = exp_q[0];
          chk("interp_x", 128'(bus.interp_x), 128'(e.x));
          chk("interp_x0", bus.interp_x0, e.x0);
          chk("interp_x1", bus.interp_x1, e.x1);
        end
      end
      if (bus.interp_done && starts_q > 0) begin
        done_cyc = cyc;
        chk("interp_x_held", 128'(bus.interp_x), 128'(st_x));
        chk("interp_x0_held", bus.interp_x0, st_x0);
        chk("interp_x1_held", bus.interp_x1, st_x1);
      end
      if (bus.res_valid && !prev_valid) rise_cyc = cyc;
      if (hold_valid && bus.res_valid) begin
        chk("res_data_stable", bus.res_data, hold_data);
        chk("res_status_stable", 128'(bus.res_status), 128'(hold_st));
      end
      if (bus.res_valid && bus.res_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: data %h status %0d with nothing expected",
                   bus.res_data, bus.res_status);
        end else begin
          e = exp_q.pop_front();
          chk("res_status", 128'(bus.res_status), 128'(e.st));
          chk("res_data", bus.res_data, e.data);
          chk("mem_reads", 128'(reads_q), 128'(e.reads));
          chk("interp_starts", 128'(starts_q), 128'(e.is_interp));
          if (e.is_interp) begin
            chk("start_latency", 128'(start_cyc - acc_cyc), 128'(1 + 2 * int'(e.reads)));
            chk("done_to_valid", 128'(rise_cyc - done_cyc), 128'(1));
          end else begin
            chk("bypass_latency", 128'(rise_cyc - acc_cyc), 128'(1 + 2 * int'(e.reads)));
          end
        end
      end
      hold_valid = bus.res_valid && !bus.res_ready;
      hold_data = bus.res_data;
      hold_st = bus.res_status;
      prev_valid = bus.res_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [63:0] x, input int len);
    int n;
    exp_q.push_back(ref_model(x, len));
    @(posedge clk);
    #1;
    bus.query_valid = 1'b1;
    bus.query_x = x;
    bus.tbl_len = 7'(len);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.query_ready && n < 5000);
    if (!bus.query_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: query x=%h not accepted in %0d cycles", x, n);
    end
    @(posedge clk);
    #1;
    bus.query_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: %0d results outstanding, want 0", exp_q.size());
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs();
    chk("rst_query_ready", 128'(bus.query_ready), 128'(0));
    chk("rst_mem_rd", 128'(bus.mem_rd), 128'(0));
    chk("rst_mem_addr", 128'(bus.mem_addr), 128'(0));
    chk("rst_interp_start", 128'(bus.interp_start), 128'(0));
    chk("rst_interp_x", 128'(bus.interp_x), 128'(0));
    chk("rst_interp_x0", bus.interp_x0, 128'(0));
    chk("rst_interp_x1", bus.interp_x1, 128'(0));
    chk("rst_res_valid", 128'(bus.res_valid), 128'(0));
    chk("rst_res_data", bus.res_data, 128'(0));
    chk("rst_res_status", 128'(bus.res_status), 128'(0));
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int n, acc0, dc0, len, j, pick;
    logic [63:0] xv, xj, q;
    bus.query_valid = 1'b0;
    bus.query_x = '0;
    bus.tbl_len = '0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 128'(bus.query_ready), 128'(1));

    // directed table {(10,100),(20,300),(40,500)}
    mem[0] = {64'd10, 64'd100};
    mem[1] = {64'd20, 64'd300};
    mem[2] = {64'd40, 64'd500};
    fixed_mode = 1'b1;
    rr_mode = 0;
    send(64'd20, 3);
    send(64'd5, 3);
    send(64'd50, 3);
    send(64'd15, 3);
    wait_drain();

    // backpressure: result held, no new query accepted
    rr_mode = 2;
    send(64'd20, 3);
    n = 0;
    while (!bus.res_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_res_valid", 128'(bus.res_valid), 128'(1));
    acc0 = n_accepts;
    @(posedge clk);
    #1;
    bus.query_valid = 1'b1;
    bus.query_x = 64'd40;
    bus.tbl_len = 7'd3;
    repeat (10) begin
      @(negedge clk);
      chk("bp_query_ready", 128'(bus.query_ready), 128'(0));
    end
    @(posedge clk);
    #1;
    bus.query_valid = 1'b0;
    rr_mode = 0;
    chk("bp_no_accept", 128'(n_accepts), 128'(acc0));
    wait_drain();

    // reset in the middle of WAIT, then a stray interp_done
    acc0 = n_starts;
    send(64'd15, 3);
    n = 0;
    while (n_starts == acc0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    chk("in_wait_before_reset", 128'(dbg_state), 128'(WAIT));
    dc0 = done_count;
    @(posedge clk);
    #1 reset_n = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    n = 0;
    while (done_count == dc0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("stray_done_fired", 128'(done_count), 128'(dc0 + 1));
    repeat (5) begin
      @(negedge clk);
      chk("stray_done_no_valid", 128'(bus.res_valid), 128'(0));
    end
    send(64'd15, 0);
    wait_drain();

    // randomized tables and queries
    fixed_mode = 1'b0;
    rr_mode = 1;
    for (int t = 0; t < 20; t++) begin
      len = (t == 0) ? 64 : $urandom_range(1, 64);
      xv = ($urandom_range(0, 4) == 0) ? 64'hFFFF_FFFF_0000_0000 : 64'($urandom_range(0, 1000));
      for (int i = 0; i < 64; i++) begin
        mem[i] = {xv, $urandom(), $urandom()};
        xv = xv + 64'($urandom_range(1, 50));
      end
      for (int k = 0; k < 8; k++) begin
        j = $urandom_range(0, len - 1);
        xj = mem[j][127:64];
        pick = $urandom_range(0, 5);
        case (pick)
          0:       q = xj;
          1:       q = xj + 64'd1;
          2:       q = xj - 64'd1;
          3:       q = 64'd0;
          4:       q = 64'hFFFF_FFFF_FFFF_FFFF;
          default: q = {$urandom(), $urandom()};
        endcase
        send(q, len);
      end
      wait_drain();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/interp_segment_finder.md
# interp_segment_finder

Upstream sequencer for the linear interpolation engine. Accepts a query abscissa, scans a sorted breakpoint table in synchronous memory to find the bracketing segment, and drives the interpolator with `x`, `x0={xa,ya}`, `x1={xb,yb}` and a start pulse. It waits for done and returns the result through a valid/ready port. Exact hits and out-of-range queries bypass the interpolator.

## Interface
- DATA_WIDTH, 128, table entry width; entry = {x[127:64], y[63:0]}, both unsigned
- ADDR_WIDTH, 6, table address width (depth up to 64)
- FRAC_BITS, 33, fractional bits of the interpolator result format; bypass results use the same format
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- query_valid  in  1  query offered
- query_ready  out  1  block idle and able to accept
- query_x  in  64  query abscissa, unsigned
- tbl_len  in  ADDR_WIDTH+1  number of valid entries; sampled at accept
- mem_rd  out  1  table read strobe
- mem_addr  out  ADDR_WIDTH  table read address
- mem_rdata  in  DATA_WIDTH  read data, valid exactly 1 cycle after mem_rd
- interp_start  out  1  one-cycle start pulse to the interpolator
- interp_x  out  64  query x to the interpolator
- interp_x0  out  DATA_WIDTH  lower entry {xa,ya}
- interp_x1  out  DATA_WIDTH  upper entry {xb,yb}
- interp_done  in  1  interpolator completion pulse
- interp_result  in  DATA_WIDTH  interpolator result, valid with interp_done
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts
- res_data  out  DATA_WIDTH  result
- res_status  out  2  0 interpolated, 1 clamped low, 2 clamped high, 3 exact hit

## Operation
- States: IDLE, ISSUE, CHECK, START, WAIT, OUT.
- IDLE: query_ready=1. On query_valid, latch query_x and tbl_len, set idx=0, and go to ISSUE.
  - If tbl_len==0, go directly to OUT with res_data=0 and status 1.
- ISSUE: mem_rd=1, mem_addr=idx, then go to CHECK.
- CHECK: register mem_rdata as cur and compare cur.x against x (unsigned, 64 bit).
  - cur.x==x: res_data = cur.y<<FRAC_BITS, status 3, go to OUT.
  - cur.x>x, idx==0: res_data = cur.y<<FRAC_BITS, status 1, go to OUT.
  - cur.x>x, idx>0: go to START with x0=prev, x1=cur.
  - cur.x<x, idx==len-1: res_data = cur.y<<FRAC_BITS, status 2, go to OUT.
  - cur.x<x otherwise: prev<=cur, idx++, go to ISSUE.
- START: interp_start=1 for one cycle, then go to WAIT.
- WAIT: on interp_done, capture interp_result into res_data, status 0, go to OUT.
- OUT: res_valid=1. Go to IDLE on res_ready.
- Bypass shift: y zero-extended to DATA_WIDTH, then shifted left by FRAC_BITS.
- Table entries are strictly ascending in x; behaviour on unsorted tables is undefined, but the scan still terminates within tbl_len reads.
- interp_done outside WAIT is ignored.
- query_valid while not IDLE is not accepted.

## Timing
- Reset values: query_ready=0 during reset and 1 from the first cycle after release.
- Reset values: mem_rd, mem_addr, interp_start, interp_x, interp_x0, interp_x1, res_valid, res_data and res_status are all 0.
- Reset mid-operation aborts to IDLE; a late interp_done is then ignored.
- Accept cycle = T. Entry k is read (ISSUE) at T+1+2k and checked (CHECK) at T+2+2k.
- Bypass result: res_valid rises at T+3+2k.
- Interpolated result: interp_start at T+3+2k; res_valid rises the cycle after interp_done.
- interp_x, interp_x0 and interp_x1 are registered, set in the cycle before START, and held stable through WAIT.
- res_data and res_status are held stable while res_valid && !res_ready.
- Throughput: one query in flight; the next query can be accepted the cycle after the res_valid && res_ready handshake.

## Structure
- Shared package `interp_pkg` holds:
  - state enum
  - status codes (ST_INTERP, ST_CLAMP_LO, ST_CLAMP_HI, ST_HIT)
  - FRAC_BITS default
  - entry field slice helpers (entry_x, entry_y)
- No sub-module is natural. Compare and select logic stays inline.
- The integration top connects this block's interp_* ports to the interpolator.

## Test plan
Table for all scenarios: {(10,100),(20,300),(40,500)}, tbl_len=3, memory model with 1-cycle read latency.
- query_x=20 -> status 3, res_data=300<<33, res_valid at T+5, no interp_start.
- query_x=5 -> status 1, res_data=100<<33, exactly one mem_rd (addr 0), res_valid at T+3.
- query_x=50 -> reads at addresses 0,1,2, then status 2, res_data=500<<33 at T+7.
- query_x=15 -> interp_start at T+5 with interp_x=15, x0={10,100}, x1={20,300}; model asserts done 130 cycles later with 0xABC -> res_data=0xABC, status 0.
- Backpressure: res_ready low for 10 cycles -> res_data and res_status stable, query_ready=0, and a new query_valid is not accepted.
- Reset mid-WAIT: pulse reset_n low -> all outputs are 0; a subsequent stray interp_done produces no res_valid; tbl_len=0 query -> status 1, data 0, no mem_rd.
